fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch front end. It issues one instruction-memory request at a
//   time from the current PC and advances the PC by 4 on each accepted request.
//   Each returned instruction is tagged with its PC and pushed into a circular
//   fetch queue that decode drains. A redirect reloads the PC, flushes the
//   queue, and discards the in-flight response if one is outstanding.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   pc_out            current PC from program_counter
//   pc_write_en/pc_in PC update strobe and next PC to program_counter
//   imem_req_*        request channel (valid/ready/addr)
//   imem_resp_*       response channel (single-cycle valid pulse, data)
//   redirect_*        branch/exception redirect strobe and target
//   fq_out_*          queue head to decode (valid/pc/instr, ready pops)
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int FQ_DEPTH = 4   // power of two, 2..16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_out,
  output logic        pc_write_en,
  output logic [31:0] pc_in,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fq_out_valid,
  output logic [31:0] fq_out_pc,
  output logic [31:0] fq_out_instr,
  input  logic        fq_out_ready
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  // REQ: may issue; WAIT: one request outstanding; DROP: outstanding
  // response belongs to a squashed fetch and must be thrown away.
  typedef enum logic [1:0] {REQ, WAIT, DROP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   count;
  logic [PW-1:0]   head, tail;
  logic [31:0]     req_pc;
  fq_entry_t       mem [FQ_DEPTH];
  fq_entry_t       hd;

  logic full, hs, push, pop;

  // ---------------------------------------------------------------------------
  // Datapath strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    full           = (count == CW'(FQ_DEPTH));
    // Issue gate on !full is what keeps the queue from overflowing: at most
    // one response can be in flight, and it was only requested with room left.
    imem_req_valid = !rst && (state == REQ) && !full && !redirect_valid;
    imem_req_addr  = pc_out;
    hs             = imem_req_valid && imem_req_ready;
    // A same-cycle redirect squashes the response instead of pushing it.
    push           = (state == WAIT) && imem_resp_valid && !redirect_valid;
    fq_out_valid   = !rst && (count != '0);
    pop            = fq_out_valid && fq_out_ready;
    pc_write_en    = !rst && (redirect_valid || hs);
    pc_in          = redirect_valid ? redirect_pc : pc_out + 32'd4;
    hd             = mem[head];
    fq_out_pc      = hd.pc;
    fq_out_instr   = hd.instr;
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      REQ:  if (hs) state_nxt = WAIT;
      WAIT: begin
        if (imem_resp_valid)     state_nxt = REQ;   // pushed, or squashed by redirect
        else if (redirect_valid) state_nxt = DROP;
      end
      // The stale response ends DROP even if another redirect lands with it;
      // nothing else is outstanding, so waiting longer would stall fetch.
      DROP: if (imem_resp_valid) state_nxt = REQ;
      default: state_nxt = REQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= REQ;
      count  <= '0;
      head   <= '0;
      tail   <= '0;
      req_pc <= '0;
    end else begin
      state <= state_nxt;
      if (hs) req_pc <= pc_out;
      if (redirect_valid) begin
        // Flush wins over any same-cycle push or pop.
        count <= '0;
        head  <= '0;
        tail  <= '0;
      end else begin
        if (push) tail <= tail + PW'(1);
        if (pop)  head <= head + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Queue storage needs no reset; entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= '{pc: req_pc, instr: imem_resp_data};
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_out = '0;
  logic        pc_write_en;
  logic [31:0] pc_in;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fq_out_valid;
  logic [31:0] fq_out_pc;
  logic [31:0] fq_out_instr;
  logic        fq_out_ready = 1'b0;

  always #5 clk = ~clk;

  fetch_unit #(.FQ_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .pc_out(pc_out),
    .pc_write_en(pc_write_en), .pc_in(pc_in),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fq_out_valid(fq_out_valid), .fq_out_pc(fq_out_pc),
    .fq_out_instr(fq_out_instr), .fq_out_ready(fq_out_ready)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  // One cycle of stimulus plus optional explicit expectations.
  typedef struct {
    bit          rdy, rv;
    logic [31:0] rdata;
    bit          fqr, redir;
    logic [31:0] rpc;
    bit          chk;
    bit          e_rv;
    logic [31:0] e_addr;
    bit          e_we;
    logic [31:0] e_pcin;
    bit          e_fv;
    logic [31:0] e_fpc;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: fetched-but-undecoded instructions in order, whether a
  // fetch is in flight, and whether that in-flight fetch has been squashed.
  ent_t        q[$];
  bit          pending, stale;
  logic [31:0] m_pc, m_req_pc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit rdy, bit rv, logic [31:0] rdata, bit fqr, bit redir,
                              logic [31:0] rpc, bit c, bit e_rv, logic [31:0] e_addr,
                              bit e_we, logic [31:0] e_pcin, bit e_fv, logic [31:0] e_fpc);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.fqr = fqr; v.redir = redir; v.rpc = rpc;
    v.chk = c; v.e_rv = e_rv; v.e_addr = e_addr; v.e_we = e_we; v.e_pcin = e_pcin;
    v.e_fv = e_fv; v.e_fpc = e_fpc;
    return v;
  endfunction

  function automatic vec_t inp(bit rdy, bit rv, logic [31:0] rdata, bit fqr);
    return mk(rdy, rv, rdata, fqr, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic model_reset();
    q.delete();
    pending = 0; stale = 0; m_pc = '0; m_req_pc = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    imem_req_ready = 0; imem_resp_valid = 0; redirect_valid = 0; fq_out_ready = 0;
    pc_out = '0;
    #1;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 0);
    chk("rst_pc_write_en", {31'b0, pc_write_en}, 0);
    chk("rst_fq_valid", {31'b0, fq_out_valid}, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
  endtask

  task automatic cyc(input vec_t v, output bit hs);
    bit e_rv, e_we, e_fv, pop, push;
    logic [31:0] e_pcin;
    @(negedge clk);
    pc_out = m_pc;
    imem_req_ready = v.rdy; imem_resp_valid = v.rv; imem_resp_data = v.rdata;
    fq_out_ready = v.fqr; redirect_valid = v.redir; redirect_pc = v.rpc;
    #1;
    e_rv   = !pending && (q.size() < D) && !v.redir;
    e_we   = v.redir || (e_rv && v.rdy);
    e_pcin = v.redir ? v.rpc : m_pc + 32'd4;
    e_fv   = (q.size() != 0);
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, e_rv});
    if (e_rv) chk("req_addr", imem_req_addr, m_pc);
    chk("pc_write_en", {31'b0, pc_write_en}, {31'b0, e_we});
    if (e_we) chk("pc_in", pc_in, e_pcin);
    chk("fq_valid", {31'b0, fq_out_valid}, {31'b0, e_fv});
    if (e_fv) begin
      chk("fq_pc", fq_out_pc, q[0].pc);
      chk("fq_instr", fq_out_instr, q[0].instr);
    end
    if (v.chk) begin
      chk("vec_req_valid", {31'b0, imem_req_valid}, {31'b0, v.e_rv});
      if (v.e_rv) chk("vec_req_addr", imem_req_addr, v.e_addr);
      chk("vec_pc_write_en", {31'b0, pc_write_en}, {31'b0, v.e_we});
      if (v.e_we) chk("vec_pc_in", pc_in, v.e_pcin);
      chk("vec_fq_valid", {31'b0, fq_out_valid}, {31'b0, v.e_fv});
      if (v.e_fv) chk("vec_fq_pc", fq_out_pc, v.e_fpc);
    end
    hs   = e_rv && v.rdy;
    pop  = e_fv && v.fqr;
    push = pending && !stale && v.rv && !v.redir;
    if (v.redir) q.delete();
    else begin
      if (pop)  q.delete(0);
      if (push) q.push_back('{pc: m_req_pc, instr: v.rdata});
    end
    if (hs) begin pending = 1; stale = 0; m_req_pc = m_pc; end
    else if (pending && v.rv) begin pending = 0; stale = 0; end
    else if (pending && v.redir) stale = 1;
    if (v.redir) m_pc = v.rpc;
    else if (hs) m_pc = m_pc + 32'd4;
  endtask

  vec_t tab[$];
  bit   hs;

  task automatic run_tab();
    foreach (tab[i]) cyc(tab[i], hs);
    tab.delete();
  endtask

  initial begin
    int resp_at;
    vec_t v;
    model_reset();

    // Basic fetch, fill to depth 4, stall, one pop reopens issue.
    do_reset();
    //             rdy rv data          fqr rd rpc c  erv addr      we pcin      fv fpc
    tab.push_back(mk(1, 0, 0,            0, 0, 0, 1, 1, 32'h0,  1, 32'h4,  0, 0));
    tab.push_back(mk(1, 1, 32'h13,       0, 0, 0, 1, 0, 0,      0, 0,      0, 0));
    tab.push_back(mk(1, 0, 0,            0, 0, 0, 1, 1, 32'h4,  1, 32'h8,  1, 32'h0));
    tab.push_back(mk(1, 1, 32'hA1,       0, 0, 0, 1, 0, 0,      0, 0,      1, 32'h0));
    tab.push_back(mk(1, 0, 0,            0, 0, 0, 1, 1, 32'h8,  1, 32'hC,  1, 32'h0));
    tab.push_back(mk(1, 1, 32'hA2,       0, 0, 0, 1, 0, 0,      0, 0,      1, 32'h0));
    tab.push_back(mk(1, 0, 0,            0, 0, 0, 1, 1, 32'hC,  1, 32'h10, 1, 32'h0));
    tab.push_back(mk(1, 1, 32'hA3,       0, 0, 0, 1, 0, 0,      0, 0,      1, 32'h0));
    tab.push_back(mk(1, 0, 0,            0, 0, 0, 1, 0, 0,      0, 0,      1, 32'h0));
    tab.push_back(mk(1, 0, 0,            0, 0, 0, 1, 0, 0,      0, 0,      1, 32'h0));
    tab.push_back(mk(1, 0, 0,            1, 0, 0, 1, 0, 0,      0, 0,      1, 32'h0));
    tab.push_back(mk(1, 0, 0,            0, 0, 0, 1, 1, 32'h10, 1, 32'h14, 1, 32'h4));
    run_tab();

    // Redirect while waiting; late response must be dropped.
    do_reset();
    tab.push_back(mk(1, 0, 0,            0, 0, 0,        1, 1, 32'h0,   1, 32'h4,   0, 0));
    tab.push_back(mk(1, 0, 0,            0, 1, 32'h100,  1, 0, 0,       1, 32'h100, 0, 0));
    tab.push_back(mk(1, 1, 32'hDEAD,     0, 0, 0,        1, 0, 0,       0, 0,       0, 0));
    tab.push_back(mk(1, 0, 0,            0, 0, 0,        1, 1, 32'h100, 1, 32'h104, 0, 0));
    tab.push_back(mk(1, 1, 32'h55,       0, 0, 0,        1, 0, 0,       0, 0,       0, 0));
    tab.push_back(mk(0, 0, 0,            0, 0, 0,        1, 1, 32'h104, 0, 0,       1, 32'h100));
    run_tab();

    // Redirect coincident with response; then a stray response in REQ.
    do_reset();
    tab.push_back(mk(1, 0, 0,            0, 0, 0,        1, 1, 32'h0,   1, 32'h4,   0, 0));
    tab.push_back(mk(1, 1, 32'hBEEF,     0, 1, 32'h200,  1, 0, 0,       1, 32'h200, 0, 0));
    tab.push_back(mk(0, 1, 32'hCAFE,     0, 0, 0,        1, 1, 32'h200, 0, 0,       0, 0));
    tab.push_back(mk(1, 0, 0,            0, 0, 0,        1, 1, 32'h200, 1, 32'h204, 0, 0));
    tab.push_back(mk(0, 1, 32'h77,       0, 0, 0,        1, 0, 0,       0, 0,       0, 0));
    tab.push_back(mk(0, 0, 0,            0, 0, 0,        1, 1, 32'h204, 0, 0,       1, 32'h200));
    run_tab();

    // Hold two entries while pushing and popping together; pointers wrap.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      cyc(inp(1, 0, 0, 0), hs);
      cyc(inp(1, 1, 32'h1000 + i, 0), hs);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(inp(1, 0, 0, 0), hs);
      cyc(inp(1, 1, 32'h2000 + i, 1), hs);
    end
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h1C, 0, 0, 1, 32'h14));
    run_tab();

    // Reset while a request is outstanding with one entry queued.
    do_reset();
    cyc(inp(1, 0, 0, 0), hs);
    cyc(inp(1, 1, 32'h33, 0), hs);
    cyc(inp(1, 0, 0, 0), hs);
    do_reset();
    tab.push_back(mk(0, 1, 32'h99, 0, 0, 0, 1, 1, 32'h0, 0, 0,     0, 0));
    tab.push_back(mk(0, 0, 0,      0, 0, 0, 1, 1, 32'h0, 0, 0,     0, 0));
    tab.push_back(mk(1, 0, 0,      0, 0, 0, 1, 1, 32'h0, 1, 32'h4, 0, 0));
    run_tab();

    // Random traffic against the model.
    do_reset();
    resp_at = -1;
    for (int i = 0; i < 3000; i++) begin
      v = inp((($urandom % 4) != 0), 0, $urandom, ($urandom % 2) == 1);
      v.redir = (($urandom % 16) == 0);
      v.rpc = (($urandom % 4) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      if (resp_at == 0) v.rv = 1;
      else if (!pending && resp_at < 0 && ($urandom % 8) == 0) v.rv = 1;
      cyc(v, hs);
      if (resp_at >= 0) resp_at--;
      if (hs) resp_at = $urandom_range(0, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
